// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, ALU operation and immediate-format enums,
// and the per-instruction control bundle carried through ID/EX.
package rv32_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_sel_e;

   typedef struct packed {
      logic alu_src_imm;
      logic alu_src_pc;
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic branch;
      logic jal;
      logic jalr;
      logic illegal;
   } ctrl_t;

   // alt selects SUB for funct3=000 and SRA for funct3=101
   function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; every format sign-extends from instr[31].
module imm_gen
   import rv32_pkg::*;
(
   input  logic [31:7] i_instr,
   input  imm_sel_e    i_sel,
   output logic [31:0] o_imm
);

   always_comb begin
      o_imm = {{21{i_instr[31]}}, i_instr[30:20]};
      case (i_sel)
         IMM_S:   o_imm = {{21{i_instr[31]}}, i_instr[30:25], i_instr[11:7]};
         IMM_B:   o_imm = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U:   o_imm = {i_instr[31:12], 12'b0};
         IMM_J:   o_imm = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
         default: o_imm = {{21{i_instr[31]}}, i_instr[30:20]};
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decoder, WB-to-ID bypass, load-use hazard detection
// and the ID/EX pipeline register with stall/flush control.
module id_stage
   import rv32_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [31:0] id_instr,
   input  logic [31:0] id_pc,
   input  logic        flush,
   output logic [4:0]  rs1_reg,
   output logic [4:0]  rs2_reg,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        wb_enable,
   input  logic [4:0]  wb_reg,
   input  logic [31:0] wb_data,
   output logic        stall,
   output logic        ex_valid,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_rs1_data,
   output logic [31:0] ex_rs2_data,
   output logic [4:0]  ex_rs1,
   output logic [4:0]  ex_rs2,
   output logic [4:0]  ex_rd,
   output logic [31:0] ex_imm,
   output logic [3:0]  ex_alu_op,
   output logic        ex_alu_src_imm,
   output logic        ex_alu_src_pc,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_reg_write,
   output logic        ex_branch,
   output logic        ex_jal,
   output logic        ex_jalr,
   output logic        ex_illegal,
   output logic [2:0]  ex_funct3
);

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [31:0] w_imm;
   logic [31:0] w_rs1_val;
   logic [31:0] w_rs2_val;
   imm_sel_e    w_imm_sel;
   alu_op_e     w_alu_op;
   ctrl_t       w_ctrl;
   logic        w_use_rs1;
   logic        w_use_rs2;
   logic        w_legal;
   logic        w_hazard;

   logic        r_ex_valid;
   logic [31:0] r_ex_pc;
   logic [31:0] r_ex_rs1_data;
   logic [31:0] r_ex_rs2_data;
   logic [4:0]  r_ex_rs1;
   logic [4:0]  r_ex_rs2;
   logic [4:0]  r_ex_rd;
   logic [31:0] r_ex_imm;
   alu_op_e     r_ex_alu_op;
   logic [2:0]  r_ex_funct3;
   ctrl_t       r_ex_ctrl;

   assign w_opcode = id_instr[6:0];
   assign w_rd     = id_instr[11:7];
   assign w_funct3 = id_instr[14:12];
   assign w_rs1    = id_instr[19:15];
   assign w_rs2    = id_instr[24:20];
   assign w_funct7 = id_instr[31:25];
   assign rs1_reg  = w_rs1;
   assign rs2_reg  = w_rs2;

   always_comb begin
      w_ctrl    = '0;
      w_alu_op  = ALU_ADD;
      w_imm_sel = IMM_I;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      w_legal   = 1'b1;
      case (w_opcode)
         OPC_LUI: begin
            w_imm_sel = IMM_U;
            w_alu_op  = ALU_PASSB;
            w_ctrl.alu_src_imm = 1'b1;
            w_ctrl.reg_write   = 1'b1;
         end
         OPC_AUIPC: begin
            w_imm_sel = IMM_U;
            w_ctrl.alu_src_imm = 1'b1;
            w_ctrl.alu_src_pc  = 1'b1;
            w_ctrl.reg_write   = 1'b1;
         end
         OPC_JAL: begin
            w_imm_sel = IMM_J;
            w_ctrl.alu_src_imm = 1'b1;
            w_ctrl.alu_src_pc  = 1'b1;
            w_ctrl.reg_write   = 1'b1;
            w_ctrl.jal         = 1'b1;
         end
         OPC_JALR: begin
            w_use_rs1 = 1'b1;
            w_legal   = (w_funct3 == 3'b000);
            w_ctrl.alu_src_imm = 1'b1;
            w_ctrl.reg_write   = 1'b1;
            w_ctrl.jalr        = 1'b1;
         end
         OPC_BRANCH: begin
            w_imm_sel = IMM_B;
            w_alu_op  = ALU_SUB;
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
            w_legal   = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
            w_ctrl.branch = 1'b1;
         end
         OPC_LOAD: begin
            w_use_rs1 = 1'b1;
            w_legal   = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
            w_ctrl.alu_src_imm = 1'b1;
            w_ctrl.mem_read    = 1'b1;
            w_ctrl.reg_write   = 1'b1;
         end
         OPC_STORE: begin
            w_imm_sel = IMM_S;
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
            w_legal   = (w_funct3[2] == 1'b0) && (w_funct3 != 3'b011);
            w_ctrl.alu_src_imm = 1'b1;
            w_ctrl.mem_write   = 1'b1;
         end
         OPC_OPIMM: begin
            w_use_rs1 = 1'b1;
            w_alu_op  = alu_from_funct(w_funct3, id_instr[30] && (w_funct3 == 3'b101));
            if (w_funct3 == 3'b001)
               w_legal = (w_funct7 == 7'h00);
            else if (w_funct3 == 3'b101)
               w_legal = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
            w_ctrl.alu_src_imm = 1'b1;
            w_ctrl.reg_write   = 1'b1;
         end
         OPC_OP: begin
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
            w_alu_op  = alu_from_funct(w_funct3, id_instr[30]);
            // 0100000 only modifies ADD (to SUB) and SRL (to SRA)
            w_legal   = (w_funct7 == 7'h00) ||
                        ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
            w_ctrl.reg_write = 1'b1;
         end
         OPC_FENCE, OPC_SYSTEM: begin
            w_use_rs1 = 1'b1;
         end
         default: w_legal = 1'b0;
      endcase
      if (!w_legal) begin
         w_ctrl         = '0;
         w_ctrl.illegal = 1'b1;
      end
      if (w_rd == 5'd0)
         w_ctrl.reg_write = 1'b0;
   end

   imm_gen u_imm_gen (
      .i_instr (id_instr[31:7]),
      .i_sel   (w_imm_sel),
      .o_imm   (w_imm)
   );

   // The register file returns the old value for a same-cycle write, so bypass it here.
   assign w_rs1_val = (wb_enable && (wb_reg == w_rs1) && (w_rs1 != 5'd0)) ? wb_data : rs1_data;
   assign w_rs2_val = (wb_enable && (wb_reg == w_rs2) && (w_rs2 != 5'd0)) ? wb_data : rs2_data;

   assign w_hazard = r_ex_valid && r_ex_ctrl.mem_read && (r_ex_rd != 5'd0) && id_valid &&
                     ((w_use_rs1 && (r_ex_rd == w_rs1)) || (w_use_rs2 && (r_ex_rd == w_rs2)));
   assign stall    = w_hazard && !flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex_valid    <= 1'b0;
         r_ex_pc       <= '0;
         r_ex_rs1_data <= '0;
         r_ex_rs2_data <= '0;
         r_ex_rs1      <= '0;
         r_ex_rs2      <= '0;
         r_ex_rd       <= '0;
         r_ex_imm      <= '0;
         r_ex_alu_op   <= ALU_ADD;
         r_ex_funct3   <= '0;
         r_ex_ctrl     <= '0;
      end else begin
         // Data fields are don't-care in a bubble, so they load unconditionally.
         r_ex_pc       <= id_pc;
         r_ex_rs1_data <= w_rs1_val;
         r_ex_rs2_data <= w_rs2_val;
         r_ex_rs1      <= w_rs1;
         r_ex_rs2      <= w_rs2;
         r_ex_rd       <= w_rd;
         r_ex_imm      <= w_imm;
         r_ex_alu_op   <= w_alu_op;
         r_ex_funct3   <= w_funct3;
         if (flush || w_hazard || !id_valid) begin
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
         end else begin
            r_ex_valid <= 1'b1;
            r_ex_ctrl  <= w_ctrl;
         end
      end
   end

   assign ex_valid       = r_ex_valid;
   assign ex_pc          = r_ex_pc;
   assign ex_rs1_data    = r_ex_rs1_data;
   assign ex_rs2_data    = r_ex_rs2_data;
   assign ex_rs1         = r_ex_rs1;
   assign ex_rs2         = r_ex_rs2;
   assign ex_rd          = r_ex_rd;
   assign ex_imm         = r_ex_imm;
   assign ex_alu_op      = r_ex_alu_op;
   assign ex_funct3      = r_ex_funct3;
   assign ex_alu_src_imm = r_ex_ctrl.alu_src_imm;
   assign ex_alu_src_pc  = r_ex_ctrl.alu_src_pc;
   assign ex_mem_read    = r_ex_ctrl.mem_read;
   assign ex_mem_write   = r_ex_ctrl.mem_write;
   assign ex_reg_write   = r_ex_ctrl.reg_write;
   assign ex_branch      = r_ex_ctrl.branch;
   assign ex_jal         = r_ex_ctrl.jal;
   assign ex_jalr        = r_ex_ctrl.jalr;
   assign ex_illegal     = r_ex_ctrl.illegal;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the RV32I 5-stage pipeline, sitting between the IF/ID register and EX. It decodes the IF/ID instruction, drives the register-file read addresses, and applies WB-to-ID bypass on the returned operands. It detects load-use hazards against its own ID/EX contents and produces the registered ID/EX bundle, with stall and flush control. Output latency is one cycle: ID/EX outputs update on the posedge after an instruction is presented.

## Interface
- No parameters. XLEN is fixed at 32.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `id_valid`  in  1  IF/ID holds a valid instruction.
- `id_instr`  in  32  IF/ID instruction.
- `id_pc`  in  32  IF/ID PC.
- `flush`  in  1  taken branch or jump resolved in EX; kill the instruction in ID.
- `rs1_reg`, `rs2_reg`  out  5  register-file read addresses, combinational from `id_instr[19:15]` and `id_instr[24:20]`.
- `rs1_data`, `rs2_data`  in  32  asynchronous register-file read data.
- `wb_enable`  in  1  WB write enable (same net that drives the register file).
- `wb_reg`  in  5  WB destination register.
- `wb_data`  in  32  WB data.
- `stall`  out  1  combinational; holds PC and IF/ID this cycle.
- `ex_valid`  out  1  ID/EX valid.
- `ex_pc`  out  32  ID/EX PC.
- `ex_rs1_data`, `ex_rs2_data`  out  32  ID/EX operand values.
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5  ID/EX register indices, for EX forwarding.
- `ex_imm`  out  32  sign-extended immediate.
- `ex_alu_op`  out  4  `alu_op_e`.
- `ex_alu_src_imm`, `ex_alu_src_pc`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_branch`, `ex_jal`, `ex_jalr`, `ex_illegal`  out  1 each  control bits.
- `ex_funct3`  out  3  memory size and branch condition.

## Operation
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (decoded as NOP), SYSTEM (decoded as NOP).
- Any other opcode, or an invalid funct3/funct7 combination, sets `ex_illegal=1` and clears `reg_write`, `mem_read` and `mem_write`.
- Immediates use the I/S/B/U/J formats per the ISA, all sign-extended from `instr[31]`.
  - U-type places `instr[31:12]` in the upper bits and zeroes the low 12 bits.
  - B-type and J-type immediates have bit 0 equal to 0.
- `reg_write` is forced to 0 when rd = x0.
- Bypass: the register file does not return a value written in the same cycle. For each operand, if `wb_enable && wb_reg == rsN && rsN != 0`, the operand is `wb_data`; otherwise it is `rsN_data`.
- Operand use: rs1 is used by all supported opcodes except LUI, AUIPC and JAL. rs2 is used by BRANCH, STORE and OP only.
- Load-use hazard: `ex_valid && ex_mem_read && ex_rd != 0 && id_valid` and `ex_rd` matches a used rs1 or rs2.
- The ID/EX register updates in this priority order:
  1. `reset`: all outputs go to 0. `ex_alu_op` becomes `ALU_ADD` (encoding 0).
  2. `flush`: `ex_valid` goes to 0.
  3. Hazard: a bubble is inserted (`ex_valid=0`, all control bits 0).
  4. Otherwise the decoded bundle is loaded and `ex_valid=id_valid`.
- `stall = hazard && !flush`. A flush overrides a stall, because the stalled instruction is dead.
- A bubble always clears `ex_mem_read`, so a stall lasts exactly one cycle per load-use pair.
- When `ex_valid=0`, data fields are don't-care, but all control bits must be 0.

## Timing
- Decode, read addresses, bypass and `stall` are all combinational within the cycle.
- The ID/EX bundle is registered at the posedge, so latency is one cycle.
- The load-use penalty is one bubble. The dependent instruction reaches EX two cycles after the load.
- Reset mid-stream discards the ID/EX contents. `stall` is 0 in the cycle after reset because `ex_valid=0`.
- `flush` and `stall` in the same cycle: the flush wins, `stall=0`, and a bubble is inserted.

## Structure
- `rv32_pkg` shared package contains:
  - opcode localparams;
  - the `alu_op_e` enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB;
  - the `imm_sel_e` enum: I, S, B, U, J.
- Sub-module `imm_gen`: purely combinational; inputs are the instruction and `imm_sel_e`; output is the 32-bit immediate.
- Everything else (decoder, bypass, hazard detection, ID/EX register) lives in `id_stage`.

## Test plan
- **ADDI:** `id_instr=0x00500093` (addi x1,x0,5), valid. Next cycle requires:
  - `ex_valid=1`, `ex_rd=1`, `ex_imm=5`;
  - `ex_alu_op=ADD`, `ex_alu_src_imm=1`, `ex_reg_write=1`.
- **Load-use:** `0x0000A103` (lw x2,0(x1)) followed by `0x002101B3` (add x3,x2,x2). Requires:
  - `stall=1` for one cycle;
  - a bubble in EX (`ex_valid=0`);
  - then the add in EX with `ex_rs1=ex_rs2=2`.
- **WB bypass:** `0x00028333` (add x6,x5,x0) while `wb_enable=1`, `wb_reg=5`, `wb_data=0xDEADBEEF`, `rs1_data=0`. Requires `ex_rs1_data=0xDEADBEEF`. Repeat with `wb_reg=0`: requires `ex_rs1_data=0`.
- **Branch immediate:** `0xFE000CE3` (beq x0,x0,-8). Requires:
  - `ex_imm=0xFFFFFFF8`, `ex_branch=1`;
  - `ex_funct3=0`, `ex_reg_write=0`.
- **Flush and illegal:** the load-use pair again, with `flush=1` asserted in the hazard cycle. Requires `stall=0` and `ex_valid=0`. Separately, `0xFFFFFFFF` requires `ex_illegal=1`, `ex_reg_write=0`, `ex_mem_write=0`.
- **Reset:** `reset` asserted mid-stream with a valid load in EX. Next cycle requires all outputs 0 and `stall=0`.
